// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, arbiter FSM
// states and the machine word.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DGRANT = 3'd1,
    IGRANT = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } arb_state_t;

  typedef logic [31:0] word_t;

  localparam int unsigned ARB_TIMEOUT = 15;

  // True while a RAM transaction is being driven.
  function automatic logic is_grant(arb_state_t s);
    return (s == DGRANT) || (s == IGRANT);
  endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// Wait counter for the arbiter: counts grant cycles spent waiting on the RAM
// and flags the last allowed cycle before the grant is declared failed.
module arb_wait_cnt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

  // Next count: clear wins; the count saturates at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data has fixed priority; one transaction in flight; every output is a flop.
//
// RAM handshake: the arbiter holds ramREN/ramWEN/ramaddr/ramstore stable for
// the whole grant; the RAM answers by presenting ramstate==ACCESS (with
// ramload valid for reads) for the cycle in which the transfer completes.
// Any other ramstate means "not yet"; ERROR aborts into the sticky ERR state.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  input  logic              halt,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err,
  output arb_state_t        dbg_state
);

  arb_state_t        state_q, state_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_store_q, ram_store_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              mem_err_q, mem_err_d;
  // The data op is remembered separately because ramWEN drops in DONE.
  logic              req_wr_q, req_wr_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_tc;
  ramstate_t         rs;

  assign rs = ramstate_t'(ramstate);

  arb_wait_cnt #(.TIMEOUT(TIMEOUT)) u_wait_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (cnt_tc)
  );

  // Next state, latched request and registered outputs.
  always_comb begin
    state_d     = state_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
    iload_d     = iload_q;
    dload_d     = dload_q;
    mem_err_d   = mem_err_q;
    req_wr_d    = req_wr_q;
    cnt_clr     = !is_grant(state_q);
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
        if (dWEN || dREN) begin
          // A simultaneous read and write request is treated as a write.
          state_d     = DGRANT;
          ram_addr_d  = daddr;
          ram_store_d = dstore;
          req_wr_d    = dWEN;
          ram_wen_d   = dWEN;
          ram_ren_d   = !dWEN;
        end else if (iREN && !halt) begin
          state_d    = IGRANT;
          ram_addr_d = iaddr;
          req_wr_d   = 1'b0;
          ram_ren_d  = 1'b1;
        end
      end

      DGRANT, IGRANT: begin
        if (rs == ACCESS) begin
          state_d   = DONE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          // The load registers take the word even if the requester left;
          // the hit only fires for a requester still asking.
          if (state_q == IGRANT) begin
            iload_d = ramload;
            ihit_d  = iREN;
          end else if (req_wr_q) begin
            dhit_d = dWEN;
          end else begin
            dload_d = ramload;
            dhit_d  = dREN;
          end
        end else if ((rs == ERROR) || cnt_tc) begin
          state_d   = ERR;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          mem_err_d = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      DONE: begin
        // Requests are ignored here so a stale request cannot re-grant.
        state_d   = IDLE;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
      end

      ERR: begin
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
        mem_err_d = 1'b1;
      end

      default: begin
        state_d   = IDLE;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops RAM enables immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      iload_q     <= '0;
      dload_q     <= '0;
      mem_err_q   <= 1'b0;
      req_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      ihit_q      <= ihit_d;
      dhit_q      <= dhit_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      mem_err_q   <= mem_err_d;
      req_wr_q    <= req_wr_d;
    end
  end

  assign ramREN    = ram_ren_q;
  assign ramWEN    = ram_wen_q;
  assign ramaddr   = ram_addr_q;
  assign ramstore  = ram_store_q;
  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign iload     = iload_q;
  assign dload     = dload_q;
  assign mem_err   = mem_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run, checked
// against a word-level memory model and an expected-load queue.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dhit;
  logic [31:0] dload;
  logic        halt = 1'b0;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        mem_err;
  arb_state_t  dbg_state;

  int checks = 0;
  int failures = 0;

  // RAM device contents (indexed by what the DUT drives) and the model's
  // view of memory (indexed by what the bench requested).
  logic [31:0] ram [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [31:0] exp_iload = '0;
  logic [31:0] exp_dload = '0;

  mem_arbiter #(.TIMEOUT(TO), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit),
    .iload(iload), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dhit(dhit), .dload(dload), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // Clock and global watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_word(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  task automatic clear_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    clear_inputs();
    nRST = 1'b0;
    exp_iload = '0;
    exp_dload = '0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // One request presented in IDLE; plays the RAM with `busy` wait cycles
  // before ACCESS and checks grant, hit and loads. Starts and ends on a
  // negedge with the arbiter in IDLE.
  task automatic do_txn(input logic rd, input logic wr, input logic ir,
                        input logic hl, input logic [31:0] da,
                        input logic [31:0] ia, input logic [31:0] ds,
                        input int busy, input bit drop);
    logic        is_data, is_fetch, exp_wen, exp_hi, exp_hd;
    logic [31:0] exp_addr, exp_w;
    is_data  = rd | wr;
    is_fetch = !is_data && ir && !hl;
    dREN = rd; dWEN = wr; iREN = ir; halt = hl;
    daddr = da; iaddr = ia; dstore = ds;
    if (!is_data && !is_fetch) begin
      repeat (3) begin
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) begin
          failures++;
          $display("FAIL no_grant: ren=%b wen=%b ihit=%b dhit=%b required all 0",
                   ramREN, ramWEN, ihit, dhit);
        end
      end
      clear_inputs();
    end else begin
      exp_addr = is_data ? da : ia;
      exp_wen  = is_data && wr;
      @(negedge CLK);
      checks++;
      if (ramREN !== !exp_wen || ramWEN !== exp_wen || ramaddr !== exp_addr ||
          (exp_wen && ramstore !== ds)) begin
        failures++;
        $display("FAIL grant: ren=%b wen=%b addr=%h store=%h required ren=%b wen=%b addr=%h store=%h",
                 ramREN, ramWEN, ramaddr, ramstore, !exp_wen, exp_wen, exp_addr, ds);
      end
      if (drop) begin
        dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
      end
      for (int i = 0; i < busy; i++) begin
        ramstate = BUSY;
        @(negedge CLK);
      end
      ramstate = ACCESS;
      if (ramWEN) ram[ramaddr] = ramstore;
      else ramload = ram_rd(ramaddr);
      if (exp_wen) begin
        model_mem[da] = ds;
      end else begin
        exp_q.push_back(model_rd(exp_addr));
      end
      @(negedge CLK);
      ramstate = FREE;
      exp_hi = is_fetch && !drop;
      exp_hd = is_data && !drop;
      if (!exp_wen) begin
        exp_w = exp_q.pop_front();
        if (is_fetch) exp_iload = exp_w;
        else exp_dload = exp_w;
      end
      checks++;
      if (ihit !== exp_hi || dhit !== exp_hd) begin
        failures++;
        $display("FAIL hit: ihit=%b dhit=%b required ihit=%b dhit=%b", ihit, dhit, exp_hi, exp_hd);
      end
      checks++;
      if (iload !== exp_iload || dload !== exp_dload) begin
        failures++;
        $display("FAIL load: iload=%h dload=%h required iload=%h dload=%h",
                 iload, dload, exp_iload, exp_dload);
      end
      checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dbg_state !== DONE) begin
        failures++;
        $display("FAIL done: ren=%b wen=%b state=%0d required ren=0 wen=0 state=%0d",
                 ramREN, ramWEN, dbg_state, DONE);
      end
      clear_inputs();
      @(negedge CLK);
      checks++;
      if (ihit !== 1'b0 || dhit !== 1'b0 || dbg_state !== IDLE) begin
        failures++;
        $display("FAIL pulse_end: ihit=%b dhit=%b state=%0d required 0 0 %0d",
                 ihit, dhit, dbg_state, IDLE);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (dbg_state !== IDLE || ramREN !== 1'b0 || ramWEN !== 1'b0 || ihit !== 1'b0 ||
        dhit !== 1'b0 || iload !== '0 || dload !== '0 || mem_err !== 1'b0 ||
        ramaddr !== '0 || ramstore !== '0) begin
      failures++;
      $display("FAIL reset: state=%0d ren=%b wen=%b ihit=%b dhit=%b iload=%h dload=%h err=%b addr=%h store=%h required all 0",
               dbg_state, ramREN, ramWEN, ihit, dhit, iload, dload, mem_err, ramaddr, ramstore);
    end
    do_reset();
  endtask

  task automatic test_fetch();
    ram[32'h40] = 32'hDEADBEEF;
    model_mem[32'h40] = 32'hDEADBEEF;
    do_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 2, 1'b0);
  endtask

  task automatic test_priority();
    do_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h80, 32'h0, 1, 1'b0);
    do_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 0, 1'b0);
  endtask

  task automatic test_write();
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h12345678, 1, 1'b0);
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 0, 1'b0);
    do_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 32'hCAFE0001, 0, 1'b0);
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 32'h0, 1, 1'b0);
  endtask

  task automatic test_halt();
    do_txn(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h44, 32'h0, 0, 1'b0);
    do_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h44, 32'h0, 2, 1'b0);
  endtask

  task automatic test_drop();
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 3, 1'b1);
    do_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h4C, 32'h0, 2, 1'b1);
  endtask

  task automatic test_wait_boundary();
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, TO - 1, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    dREN = 1'b1; daddr = 32'h500;
    ramstate = BUSY;
    n = 0;
    while (n < TO + 5 && mem_err !== 1'b1) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n !== TO + 1 || mem_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_latency: mem_err after %0d cycles (err=%b) required %0d", n, mem_err, TO + 1);
    end
    checks++;
    if (dbg_state !== ERR || ramREN !== 1'b0 || dhit !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state: state=%0d ren=%b dhit=%b required %0d 0 0", dbg_state, ramREN, dhit, ERR);
    end
    ramstate = FREE;
    dREN = 1'b0;
    iREN = 1'b1; dWEN = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      checks++;
      if (dbg_state !== ERR || mem_err !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0 ||
          ihit !== 1'b0 || dhit !== 1'b0) begin
        failures++;
        $display("FAIL err_absorb: state=%0d err=%b ren=%b wen=%b ihit=%b dhit=%b required ERR 1 0 0 0 0",
                 dbg_state, mem_err, ramREN, ramWEN, ihit, dhit);
      end
    end
    do_reset();
    #1;
    checks++;
    if (mem_err !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL err_cleared: err=%b state=%0d required 0 %0d", mem_err, dbg_state, IDLE);
    end
  endtask

  task automatic test_ram_error();
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h700;
    @(negedge CLK);
    ramstate = ERROR;
    @(negedge CLK);
    checks++;
    if (dbg_state !== ERR || mem_err !== 1'b1 || ramREN !== 1'b0 || ihit !== 1'b0) begin
      failures++;
      $display("FAIL ram_error: state=%0d err=%b ren=%b ihit=%b required ERR 1 0 0",
               dbg_state, mem_err, ramREN, ihit);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_grant();
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h600;
    @(negedge CLK);
    ramstate = BUSY;
    #2 nRST = 1'b0;
    exp_iload = '0;
    exp_dload = '0;
    #1;
    checks++;
    if (ramREN !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL async_reset: ren=%b state=%0d required 0 %0d", ramREN, dbg_state, IDLE);
    end
    ramstate = FREE;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin
      failures++;
      $display("FAIL regrant: ren=%b addr=%h required 1 00000600", ramREN, ramaddr);
    end
    ramstate = ACCESS;
    ramload = ram_rd(ramaddr);
    exp_iload = model_rd(32'h600);
    @(negedge CLK);
    ramstate = FREE;
    checks++;
    if (ihit !== 1'b1 || iload !== exp_iload) begin
      failures++;
      $display("FAIL regrant_hit: ihit=%b iload=%h required 1 %h", ihit, iload, exp_iload);
    end
    clear_inputs();
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic        rd, wr, ir, hl;
    logic [31:0] da, ia, ds;
    int          op;
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 3);
      rd = (op == 1) || (op == 3);
      wr = (op == 2) || (op == 3);
      ir = 1'($urandom_range(0, 1));
      hl = ($urandom_range(0, 3) == 0);
      da = 32'h800 + 32'($urandom_range(0, 7)) * 4;
      ia = 32'h800 + 32'($urandom_range(0, 7)) * 4;
      ds = $urandom;
      do_txn(rd, wr, ir, hl, da, ia, ds, $urandom_range(0, 6), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_write();
    test_halt();
    test_drop();
    test_wait_boundary();
    test_timeout();
    test_ram_error();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
